// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request/response, fixed access latency, RV32I sizes.
// Storage is zero-initialised at time 0 and kept outside the reset domain.
module dmem_responder #(
  parameter int                AWIDTH      = 32,
  parameter int                DWIDTH      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h0100_0000,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int                IW        = $clog2(DEPTH_WORDS);
  localparam logic [AWIDTH-1:0] SPAN      = AWIDTH'(DEPTH_WORDS * 4);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q;

  logic              c_we;
  logic [AWIDTH-1:0] c_addr;
  logic [DWIDTH-1:0] c_wdata;
  logic [1:0]        c_size;
  logic              c_uns;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic              accept;
  logic              rsp_done;
  logic              enter_resp;
  logic [AWIDTH-1:0] off;
  logic [IW-1:0]     idx;
  logic [1:0]        lane;
  logic              mis;
  logic              err;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [DWIDTH-1:0] rword;
  logic [DWIDTH-1:0] wword;
  logic [DWIDTH-1:0] lext;

  assign accept     = (state_q == S_IDLE) && req_ready_o && req_valid_i;
  assign rsp_done   = (state_q == S_RESP) && rsp_valid_o && rsp_ready_i;
  assign enter_resp = (state_q == S_WAIT) && (cnt_q == 4'd0);

  assign off   = c_addr - BASE_ADDR;
  assign idx   = off[IW+1:2];
  assign lane  = c_addr[1:0];
  assign rword = mem[idx];
  assign b     = rword[{lane, 3'b000} +: 8];
  assign h     = rword[{lane[1], 4'b0000} +: 16];
  assign err   = mis || (off >= SPAN);

  always_comb begin
    mis = 1'b0;
    unique case (c_size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = c_addr[0];
      2'b10:   mis = |c_addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  // Merge only the addressed lanes into the current word
  always_comb begin
    wword = rword;
    unique case (1'b1)
      c_size == 2'b00: wword[{lane, 3'b000} +: 8]      = c_wdata[7:0];
      c_size == 2'b01: wword[{lane[1], 4'b0000} +: 16] = c_wdata[15:0];
      c_size == 2'b10: wword = c_wdata;
      default:         wword = rword;
    endcase
  end

  always_comb begin
    lext = rword;
    unique case (1'b1)
      c_size == 2'b00: lext = c_uns ? {24'b0, b} : {{24{b[7]}}, b};
      c_size == 2'b01: lext = c_uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:         lext = rword;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  if (rsp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_ready_o <= 1'b0;
      cnt_q       <= 4'd0;
      c_we        <= 1'b0;
      c_addr      <= '0;
      c_wdata     <= '0;
      c_size      <= 2'b00;
      c_uns       <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_o <= (state_d == S_IDLE);
      if (accept) begin
        c_we    <= req_we_i;
        c_addr  <= req_addr_i;
        c_wdata <= req_wdata_i;
        c_size  <= req_size_i;
        c_uns   <= req_unsigned_i;
        cnt_q   <= WAIT_INIT;
      end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= err;
        rsp_rdata_o <= (c_we || err) ? '0 : lext;
      end else if (rsp_done) begin
        rsp_valid_o <= 1'b0;
        rsp_err_o   <= 1'b0;
        rsp_rdata_o <= '0;
      end
    end
  end

  // Storage is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (enter_resp && c_we && !err)
      mem[idx] <= wword;
  end

endmodule
